srl_rr_arbiter: RTL

//  Shares one fixed-latency SRL delay-line datapath among C_NUM_REQ requesters.

---
 rtl/srl_rr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/srl_rr_arbiter.sv
// Round-robin arbiter with packet locking feeding a fixed-latency shift-register delay line.
// Requester id, last flag and data travel together through the line; one beat enters per cycle.
module srl_rr_arbiter #(
   parameter int unsigned C_NUM_REQ      = 4,
   parameter int unsigned C_ID_WIDTH     = 2,
   parameter int unsigned C_DATA_WIDTH   = 32,
   parameter int unsigned C_CLOCK_CYCLES = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en,
   input  logic [C_NUM_REQ-1:0]              req_valid,
   input  logic [C_NUM_REQ-1:0]              req_last,
   input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_data,
   output logic [C_NUM_REQ-1:0]              req_ready,
   output logic                              out_valid,
   output logic [C_ID_WIDTH-1:0]             out_id,
   output logic                              out_last,
   output logic [C_DATA_WIDTH-1:0]           out_data,
   output logic                              busy
);

   localparam int unsigned CNT_W      = $clog2(C_CLOCK_CYCLES + 1);
   localparam int unsigned LAST_STAGE = C_CLOCK_CYCLES - 1;

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   typedef struct packed {
      logic                    valid;
      logic [C_ID_WIDTH-1:0]   id;
      logic                    last;
      logic [C_DATA_WIDTH-1:0] data;
   } beat_t;

   state_t                state, state_nxt;
   logic [C_ID_WIDTH-1:0] ptr, ptr_nxt;
   logic [C_ID_WIDTH-1:0] owner, owner_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic                  grant_found;
   logic [C_ID_WIDTH-1:0] grant_id;
   beat_t                 beat_in;
   beat_t                 line [C_CLOCK_CYCLES];

   function automatic logic [C_ID_WIDTH-1:0] next_id(input logic [C_ID_WIDTH-1:0] id);
      if (32'(id) >= C_NUM_REQ - 1) return '0;
      return id + C_ID_WIDTH'(1);
   endfunction

   // Grant selection: owner only while locked, else first valid at or after the pointer.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = '0;
      req_ready   = '0;
      if (rst && en) begin
         if (state == S_LOCKED) begin
            for (int unsigned j = 0; j < C_NUM_REQ; j++) begin
               if (32'(owner) == j && req_valid[j]) begin
                  grant_found = 1'b1;
                  grant_id    = owner;
               end
            end
         end else begin
            for (int unsigned i = 0; i < C_NUM_REQ; i++) begin
               for (int unsigned j = 0; j < C_NUM_REQ; j++) begin
                  if (!grant_found && ((32'(ptr) + i) % C_NUM_REQ) == j && req_valid[j]) begin
                     grant_found = 1'b1;
                     grant_id    = C_ID_WIDTH'(j);
                  end
               end
            end
         end
         for (int unsigned j = 0; j < C_NUM_REQ; j++) begin
            req_ready[j] = grant_found && (32'(grant_id) == j);
         end
      end
   end

   // Payload of the granted requester; bubbles enter the line as all-zero beats.
   always_comb begin
      beat_in = '0;
      if (grant_found) begin
         beat_in.valid = 1'b1;
         beat_in.id    = grant_id;
         for (int unsigned j = 0; j < C_NUM_REQ; j++) begin
            if (32'(grant_id) == j) begin
               beat_in.last = req_last[j];
               beat_in.data = req_data[j*C_DATA_WIDTH +: C_DATA_WIDTH];
            end
         end
      end
   end

   // Next state, pointer, owner and in-flight count.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      cnt_nxt   = cnt;
      if (grant_found) begin
         if (beat_in.last) begin
            state_nxt = S_IDLE;
            ptr_nxt   = next_id(grant_id);
         end else begin
            state_nxt = S_LOCKED;
            owner_nxt = grant_id;
         end
      end
      case ({grant_found, line[LAST_STAGE].valid})
         2'b10:   cnt_nxt = cnt + CNT_W'(1);
         2'b01:   cnt_nxt = cnt - CNT_W'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         ptr   <= '0;
         owner <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         for (int unsigned i = 0; i < C_CLOCK_CYCLES; i++) begin
            line[i] <= '0;
         end
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         owner   <= owner_nxt;
         cnt     <= cnt_nxt;
         busy    <= (state_nxt == S_LOCKED) || (cnt_nxt != '0);
         line[0] <= beat_in;
         for (int unsigned i = 1; i < C_CLOCK_CYCLES; i++) begin
            line[i] <= line[i-1];
         end
      end
   end

   assign out_valid = line[LAST_STAGE].valid;
   assign out_id    = line[LAST_STAGE].id;
   assign out_last  = line[LAST_STAGE].last;
   assign out_data  = line[LAST_STAGE].data;

endmodule
